ps2_key_state: RTL and testbench

Converts the raw PS/2 keyboard lines into a debounced, level-style held-key mask that feeds `control_host.key[3:0]` in place of, or OR-ed with, the board buttons. It receives 11-bit PS/2 device-to-host frames and checks them, then tracks make, break (`F0`) and extended (`E0`) prefixes. It also reports every accepted scan code for LED/debug use. It sits between the top-level PS2C/PS2D pins and `control_host`, in the `clk` domain.

---
 rtl/ps2_pkg.sv | 50 +++++
 rtl/ps2_frame_rx.sv | 113 +++++++++++
 rtl/ps2_key_state.sv | 78 +++++++
 tb/tb_ps2_key_state.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, key-mask bit indices and scan-code-to-key helpers
// for the PS/2 key-state path.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;

  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  // Bit order matches the control_host en_* ordering.
  localparam int KEY_LEFT  = 3;
  localparam int KEY_RIGHT = 2;
  localparam int KEY_FWD   = 1;
  localparam int KEY_BACK  = 0;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_t;

  // Result is {hit, bit index}.
  function automatic logic [2:0] wasd_map(input logic [7:0] code);
    case (code)
      SC_A:    return {1'b1, 2'(KEY_LEFT)};
      SC_D:    return {1'b1, 2'(KEY_RIGHT)};
      SC_W:    return {1'b1, 2'(KEY_FWD)};
      SC_S:    return {1'b1, 2'(KEY_BACK)};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] arrow_map(input logic [7:0] code);
    case (code)
      SC_LEFT:  return {1'b1, 2'(KEY_LEFT)};
      SC_RIGHT: return {1'b1, 2'(KEY_RIGHT)};
      SC_UP:    return {1'b1, 2'(KEY_FWD)};
      SC_DOWN:  return {1'b1, 2'(KEY_BACK)};
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: sync, PS2C glitch filter, falling-edge detect,
// 11-bit frame FSM with timeout. byte_ok/byte_err pulse in the cycle the stop edge
// (or timeout) is detected; no backpressure, every frame is reported once.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] byte_dat,
  output logic       byte_ok,
  output logic       byte_err
);

  localparam int FC_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

  logic            c_s1, c_s2, d_s1, d_s2;
  logic            filt_lvl, filt_prev;
  logic [FC_W-1:0] filt_cnt;
  logic            fall;

  rx_state_t       state, state_nxt;
  logic [3:0]      bit_cnt;
  logic [8:0]      shreg;
  logic [TO_W-1:0] to_cnt;
  logic            frame_good;

  always_ff @(posedge clk) begin
    if (!rst) begin
      c_s1      <= 1'b1;
      c_s2      <= 1'b1;
      d_s1      <= 1'b1;
      d_s2      <= 1'b1;
      filt_lvl  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      c_s1      <= ps2c;
      c_s2      <= c_s1;
      d_s1      <= ps2d;
      d_s2      <= d_s1;
      filt_prev <= filt_lvl;
      // Any sample matching the current level restarts the run count.
      if (c_s2 == filt_lvl) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FC_MAX) begin
        filt_lvl <= c_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall       = filt_prev & ~filt_lvl;
  assign frame_good = (^shreg) & d_s2;
  assign byte_dat   = shreg[7:0];

  always_ff @(posedge clk) begin
    if (!rst) state <= RX_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    byte_ok   = 1'b0;
    byte_err  = 1'b0;
    case (state)
      RX_IDLE: if (fall && !d_s2) state_nxt = RX_RECV;
      RX_RECV: begin
        if (fall) begin
          // bit_cnt == 9 means this edge samples the stop bit.
          if (bit_cnt == 4'd9) begin
            state_nxt = RX_IDLE;
            byte_ok   = frame_good;
            byte_err  = ~frame_good;
          end
        end else if (to_cnt == TO_MAX) begin
          state_nxt = RX_IDLE;
          byte_err  = 1'b1;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      to_cnt  <= '0;
    end else if (state == RX_RECV) begin
      if (fall) begin
        shreg   <= {d_s2, shreg[8:1]};
        bit_cnt <= bit_cnt + 1'b1;
        to_cnt  <= '0;
      end else begin
        to_cnt  <= to_cnt + 1'b1;
      end
    end else begin
      bit_cnt <= '0;
      to_cnt  <= '0;
    end
  end

endmodule

// File: rtl/ps2_key_state.sv
// PS/2 keyboard to held-key mask: E0/F0 prefix tracking and WASD decode; arrow keys
// added when PS2_ARROW_KEYS_EN is defined. Outputs register 1 cycle after the stop edge.
// No backpressure: each accepted byte updates scan_code and pulses code_valid once.
module ps2_key_state
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic [3:0] key,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  logic [7:0] byte_dat;
  logic       byte_ok, byte_err;
  logic       ext_pend, brk_pend;
  logic [2:0] map;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2c     (PS2C),
    .ps2d     (PS2D),
    .byte_dat (byte_dat),
    .byte_ok  (byte_ok),
    .byte_err (byte_err)
  );

  always_comb begin
    map = 3'b000;
`ifdef PS2_ARROW_KEYS_EN
    if (ext_pend) map = arrow_map(byte_dat);
    else          map = wasd_map(byte_dat);
`else
    if (!ext_pend) map = wasd_map(byte_dat);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key        <= '0;
      scan_code  <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
    end else begin
      code_valid <= byte_ok;
      frame_err  <= byte_err;
      // A lost byte may have been a prefix; start the next byte fresh.
      if (byte_err) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_ok) begin
        scan_code <= byte_dat;
        if (byte_dat == SC_EXT) begin
          ext_pend <= 1'b1;
        end else if (byte_dat == SC_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
          if (map[2]) key[map[1:0]] <= ~brk_pend;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_state.sv
// Directed bench for ps2_key_state: bit-banged PS/2 frames, immediate-assertion checks.
module tb_ps2_key_state;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 300;
  localparam int HALF       = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       PS2C = 1'b1;
  logic       PS2D = 1'b1;
  logic [3:0] key;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int cv_cnt = 0, fe_cnt = 0, both_cnt = 0, cv_dbl = 0, fe_dbl = 0;
  int cv0, fe0, lat;
  logic cv_prev = 1'b0, fe_prev = 1'b0;

  ps2_key_state #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .PS2C       (PS2C),
    .PS2D       (PS2D),
    .key        (key),
    .scan_code  (scan_code),
    .code_valid (code_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) cv_cnt++;
    if (frame_err) fe_cnt++;
    if (code_valid && frame_err) both_cnt++;
    if (code_valid && cv_prev) cv_dbl++;
    if (frame_err && fe_prev) fe_dbl++;
    cv_prev = code_valid;
    fe_prev = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // Clocks out bits first..last of a frame (index 0 = start, 10 = stop).
  task automatic send_bits(input logic [10:0] bits, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      PS2D = bits[i];
      wait_cyc(HALF / 2);
      PS2C = 1'b0;
      wait_cyc(HALF);
      PS2C = 1'b1;
      wait_cyc(HALF / 2);
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(frame(b, 1'b0), 0, 10);
    wait_cyc(HALF);
  endtask

  task automatic send_bad(input logic [7:0] b);
    send_bits(frame(b, 1'b1), 0, 10);
    wait_cyc(HALF);
  endtask

  initial begin
    wait_cyc(4);
    check("rst_key", 32'(key), 32'h0);
    check("rst_scan", 32'(scan_code), 32'h0);
    check("rst_cv", 32'(code_valid), 32'h0);
    check("rst_fe", 32'(frame_err), 32'h0);
    rst = 1'b1;
    wait_cyc(4);

    // Make A, measuring stop-edge to code_valid latency.
    cv0 = cv_cnt;
    send_bits(frame(8'h1C, 1'b0), 0, 9);
    PS2D = 1'b1;
    wait_cyc(HALF / 2);
    PS2C = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (code_valid) break;
    end
    check("make_a_latency", 32'(lat), 32'(2 + FILTER_LEN + 1));
    wait_cyc(HALF);
    PS2C = 1'b1;
    wait_cyc(HALF);
    check("make_a_scan", 32'(scan_code), 32'h1C);
    check("make_a_key", 32'(key), 32'h8);
    check("make_a_cv", 32'(cv_cnt - cv0), 32'd1);

    send(8'h1D);
    check("make_w_key", 32'(key), 32'hA);

    // Break A
    cv0 = cv_cnt;
    send(8'hF0);
    check("brk_f0_key", 32'(key), 32'hA);
    check("brk_f0_scan", 32'(scan_code), 32'hF0);
    send(8'h1C);
    check("brk_a_key", 32'(key), 32'h2);
    check("brk_a_cv", 32'(cv_cnt - cv0), 32'd2);

    send(8'hF0);
    send(8'h1D);
    check("brk_w_key", 32'(key), 32'h0);

    // Parity error then good W
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    send_bad(8'h1D);
    check("par_fe", 32'(fe_cnt - fe0), 32'd1);
    check("par_cv", 32'(cv_cnt - cv0), 32'd0);
    check("par_key", 32'(key), 32'h0);
    send(8'h1D);
    check("par_good_key", 32'(key), 32'h2);

    // Timeout after start + 4 bits
    fe0 = fe_cnt;
    cv0 = cv_cnt;
    send_bits(frame(8'h23, 1'b0), 0, 4);
    wait_cyc(TIMEOUT + 40);
    check("to_fe", 32'(fe_cnt - fe0), 32'd1);
    check("to_cv", 32'(cv_cnt - cv0), 32'd0);
    send(8'h23);
    check("to_next_key", 32'(key), 32'h6);

    // A bad frame drops a pending break: next D is a make
    send(8'hF0);
    send_bad(8'h23);
    send(8'h23);
    check("err_clr_brk_key", 32'(key), 32'h6);

    // Auto-repeat make is a no-op
    send(8'h23);
    check("repeat_key", 32'(key), 32'h6);

    send(8'hF0);
    send(8'h1D);
    check("rel_w_key", 32'(key), 32'h4);

    // Extended up arrow
    send(8'hE0);
    send(8'h75);
    check("ext_scan", 32'(scan_code), 32'h75);
`ifdef PS2_ARROW_KEYS_EN
    check("up_make_key", 32'(key), 32'h6);
`else
    check("up_make_key", 32'(key), 32'h4);
`endif
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("up_brk_key", 32'(key), 32'h4);
    send(8'h1D);
    check("w_again_key", 32'(key), 32'h6);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
`ifdef PS2_ARROW_KEYS_EN
    check("up_brk_w_key", 32'(key), 32'h4);
`else
    check("up_brk_w_key", 32'(key), 32'h6);
`endif
    // Pending flags must be clear again: plain S is a make
    send(8'h1B);
    check("s_after_ext_key", 32'(key), 32'h1 | ((`ifdef PS2_ARROW_KEYS_EN 32'h4 `else 32'h6 `endif)));
    send(8'hF0);
    send(8'h1B);

    // Mid-frame reset during 0x1B
    cv0 = cv_cnt;
    send_bits(frame(8'h1B, 1'b0), 0, 5);
    rst = 1'b0;
    wait_cyc(1);
    rst = 1'b1;
    check("mid_rst_key", 32'(key), 32'h0);
    send_bits(frame(8'h1B, 1'b0), 6, 10);
    wait_cyc(TIMEOUT + 40);
    check("mid_rst_cv", 32'(cv_cnt - cv0), 32'd0);
    check("mid_rst_key2", 32'(key), 32'h0);
    send(8'h1B);
    check("fresh_s_key", 32'(key), 32'h1);
    check("fresh_s_scan", 32'(scan_code), 32'h1B);

    check("cv_fe_overlap", 32'(both_cnt), 32'd0);
    check("cv_one_cycle", 32'(cv_dbl), 32'd0);
    check("fe_one_cycle", 32'(fe_dbl), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
